// File: rtl/shift_deserializer_rx.sv
// Serial-to-parallel receiver: start-framed, MSB- or LSB-first, with a valid/ready holding register.
// Optional trailing even-parity bit is enabled with the SHIFT_RX_PARITY_EN macro.
module shift_deserializer_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_start,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             abort,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             par_err
);

  localparam int unsigned       CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]   LastCnt = CntW'(WIDTH - 1);

`ifdef SHIFT_RX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StRecv, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRecv} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             abort_q, abort_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q, overrun_d;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
`ifdef SHIFT_RX_PARITY_EN
  logic             commit_err;
  logic             par_err_q, par_err_d;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh, input logic d,
                                                input logic b);
    return d ? {b, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], b};
  endfunction

  // Frame assembly; a start bit always (re)opens a frame, aborting any frame in progress.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    abort_d     = 1'b0;
    commit      = 1'b0;
    commit_word = sh_q;
`ifdef SHIFT_RX_PARITY_EN
    commit_err  = 1'b0;
`endif
    if (ser_valid) begin
      if (ser_start) begin
        abort_d = (state_q != StIdle);
        dir_d   = dir;
        sh_d    = shift_in(sh_q, dir, ser_in);
        cnt_d   = CntW'(1);
        state_d = StRecv;
      end else begin
        unique case (state_q)
          StRecv: begin
            sh_d = shift_in(sh_q, dir_q, ser_in);
            if (cnt_q == LastCnt) begin
              cnt_d = '0;
`ifdef SHIFT_RX_PARITY_EN
              state_d = StParity;
`else
              state_d     = StIdle;
              commit      = 1'b1;
              commit_word = sh_d;
`endif
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
`ifdef SHIFT_RX_PARITY_EN
          StParity: begin
            state_d     = StIdle;
            commit      = 1'b1;
            commit_word = sh_q;
            commit_err  = (^sh_q) ^ ser_in;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Holding register: a completed word is dropped (overrun) only if the old one is not taken now.
  always_comb begin
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;
`ifdef SHIFT_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (ovr_clr) overrun_d = 1'b0;
    if (commit) begin
      if (!par_valid_q || par_ready) begin
        par_out_d   = commit_word;
        par_valid_d = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
        par_err_d   = commit_err;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (par_valid_q && par_ready) begin
      par_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      abort_q     <= 1'b0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      abort_q     <= abort_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
`ifdef SHIFT_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign busy      = (state_q != StIdle);
  assign abort     = abort_q;
  assign overrun   = overrun_q;
`ifdef SHIFT_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer_rx.sv
// Bench for shift_deserializer_rx: directed frames then random traffic against a frame-level model.
// Follows SHIFT_RX_PARITY_EN the same way as the design.
module tb_shift_deserializer_rx;
  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         Clear_b = 1'b0;
  logic         ser_in = 1'b0, ser_valid = 1'b0, ser_start = 1'b0, dir = 1'b0;
  logic         par_ready = 1'b0, ovr_clr = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid, busy, abort, overrun, par_err;

  shift_deserializer_rx #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .Clear_b   (Clear_b),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_start (ser_start),
    .dir       (dir),
    .par_out   (par_out),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .busy      (busy),
    .abort     (abort),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .par_err   (par_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Frame-level model: collected bits in arrival order plus the output register contents.
  bit           fr_bits[$];
  bit           fr_dir;
  bit           in_frame;
  bit           await_par;
  logic [W-1:0] exp_out;
  logic         exp_valid, exp_ovr, exp_abort, exp_err;

`ifdef SHIFT_RX_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] frame_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (fr_dir == 1'b0) w[W-1-i] = fr_bits[i];
      else                w[i]     = fr_bits[i];
    end
    return w;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".par_out"},   32'(par_out),   32'(exp_out));
    check({tag, ".par_valid"}, 32'(par_valid), 32'(exp_valid));
    check({tag, ".busy"},      32'(busy),      32'(in_frame));
    check({tag, ".abort"},     32'(abort),     32'(exp_abort));
    check({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
    check({tag, ".par_err"},   32'(par_err),   32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Clear_b = 1'b0; ser_valid = 1'b0; ser_start = 1'b0; par_ready = 1'b0; ovr_clr = 1'b0;
    @(posedge CLK);
    fr_bits.delete();
    in_frame = 0; await_par = 0; fr_dir = 0;
    exp_out = '0; exp_valid = 0; exp_ovr = 0; exp_abort = 0; exp_err = 0;
    #1 check_all("reset");
    @(negedge CLK);
    Clear_b = 1'b1;
  endtask

  // One clock with the given inputs, then model update and full output comparison.
  task automatic cycle(input string tag, input bit v, input bit s, input bit d, input bit b,
                       input bit rdy, input bit oc);
    bit           commit = 0, ovr_set = 0;
    logic [W-1:0] word = '0;
    bit           err = 0;
    @(negedge CLK);
    ser_valid = v; ser_start = s; dir = d; ser_in = b; par_ready = rdy; ovr_clr = oc;
    @(posedge CLK);
    exp_abort = 0;
    if (v) begin
      if (s) begin
        exp_abort = in_frame;
        fr_bits.delete();
        fr_bits.push_back(b);
        fr_dir = d; in_frame = 1; await_par = 0;
      end else if (in_frame) begin
        if (await_par) begin
          word = frame_word(); err = (^word) ^ b; commit = 1; in_frame = 0;
        end else begin
          fr_bits.push_back(b);
          if (fr_bits.size() == W) begin
            if (ParityEn) await_par = 1;
            else begin word = frame_word(); commit = 1; in_frame = 0; end
          end
        end
      end
    end
    if (commit) begin
      if (!exp_valid || rdy) begin
        exp_out = word; exp_valid = 1; exp_err = err;
      end else ovr_set = 1;
    end else if (exp_valid && rdy) exp_valid = 0;
    if (oc) exp_ovr = 0;
    if (ovr_set) exp_ovr = 1;
    #1 check_all(tag);
  endtask

  // Start-framed word; seq[W-1] goes out first. rdy applies only on the completing edge.
  task automatic send_frame(input string tag, input bit d, input logic [W-1:0] seq,
                            input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      bit last = (i == 0) && !ParityEn;
      cycle(tag, 1, i == W - 1, d, seq[i], last ? rdy_last : 1'b0, 0);
    end
    if (ParityEn) cycle(tag, 1, 0, d, ^seq, rdy_last, 0);
  endtask

  initial begin
    do_reset();

    // Mid-frame reset, then a clean frame.
    cycle("pre", 1, 1, 0, 1, 0, 0);
    cycle("pre", 1, 0, 0, 1, 0, 0);
    do_reset();
    send_frame("after_rst", 0, 4'b1010, 0);
    check("after_rst.word", 32'(par_out), 32'h0000_000a);
    cycle("drain", 0, 0, 0, 0, 1, 0);

    send_frame("msb", 0, 4'b1010, 0);
    cycle("msb_take", 0, 0, 0, 0, 1, 0);
    send_frame("lsb", 1, 4'b1010, 0);
    check("lsb.word", 32'(par_out), 32'h0000_0005);
    cycle("lsb_take", 0, 0, 0, 0, 1, 0);

    // Overrun then clear, then the same with the consumer taking on the completion edge.
    send_frame("ovr1", 0, 4'b1100, 0);
    send_frame("ovr2", 0, 4'b0011, 0);
    check("ovr.held", 32'(par_out), 32'h0000_000c);
    check("ovr.flag", 32'(overrun), 32'h1);
    cycle("ovr_clr", 0, 0, 0, 0, 0, 1);
    send_frame("ovr3", 0, 4'b0011, 1);
    check("ovr3.word", 32'(par_out), 32'h0000_0003);
    cycle("ovr_take", 0, 0, 0, 0, 1, 0);

    // Restart mid-frame.
    cycle("rst_a", 1, 1, 0, 1, 0, 0);
    cycle("rst_b", 1, 0, 0, 1, 0, 0);
    send_frame("restart", 0, 4'b0001, 0);
    check("restart.word", 32'(par_out), 32'h0000_0001);
    cycle("restart_take", 0, 0, 0, 0, 1, 0);

    // Gaps between bits; with parity enabled, both parity-bit values.
    for (int p = 0; p < 2; p++) begin
      cycle("gap", 1, 1, 0, 1, 0, 0);
      cycle("gap", 0, 0, 0, 0, 0, 0);
      cycle("gap", 1, 0, 0, 0, 0, 0);
      cycle("gap", 0, 0, 0, 1, 0, 0);
      cycle("gap", 1, 0, 0, 1, 0, 0);
      cycle("gap", 0, 0, 0, 0, 0, 0);
      cycle("gap", 1, 0, 0, 0, 0, 0);
      if (ParityEn) begin
        cycle("gap", 0, 0, 0, 0, 0, 0);
        cycle("gap_par", 1, 0, 0, p == 0, 0, 0);
      end
      check("gap.word", 32'(par_out), 32'h0000_000a);
      cycle("gap_take", 0, 0, 0, 0, 1, 0);
    end

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      bit s   = ($urandom_range(0, 7) == 0);
      cycle("rand", v, s, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
